gray2bin_tracker: RTL and testbench

GRAY2BIN_TRACKER -- requirements
Module: gray2bin_tracker

---
 rtl/gray2bin_tracker.sv | 169 ++++++++++++++++
 tb/tb_gray2bin_tracker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray2bin_tracker.sv
// -----------------------------------------------------------------------------
// gray2bin_tracker
//
// Captures a Gray-coded position sample, decodes it to binary one cycle later
// and tracks single-step movement of the decoded value in an 8-bit signed
// position accumulator. Steps of more than one code are flagged as illegal and
// park the tracker in an ERROR state until err_clr is asserted.
//
// Optional feature macro: GRAY_ERR_CNT_EN
//   defined   -> err_cnt counts illegal steps, saturating at 255
//   undefined -> err_cnt is tied to 0 and no counter exists
//
// Parameters:
//   W         Gray/binary code width (2..8)
//
// Ports:
//   clk       input   single clock, rising-edge active
//   rst_n     input   asynchronous active-low reset
//   g         input   Gray-coded sample [W-1:0]
//   g_valid   input   g is valid this cycle
//   err_clr   input   leave ERROR state (ignored elsewhere)
//   b         output  registered decoded binary value [W-1:0]
//   b_valid   output  one-cycle pulse when b and tracking outputs update
//   pos       output  two's-complement position accumulator [7:0]
//   dir       output  direction of last legal step, 1 = up
//   step_err  output  one-cycle pulse on an illegal step
//   err_cnt   output  illegal-step count [7:0]
// -----------------------------------------------------------------------------
module gray2bin_tracker #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] g,
    input  logic         g_valid,
    input  logic         err_clr,
    output logic [W-1:0] b,
    output logic         b_valid,
    output logic [7:0]   pos,
    output logic         dir,
    output logic         step_err,
    output logic [7:0]   err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam logic [W-1:0] STEP_UP   = W'(1);
    localparam logic [W-1:0] STEP_DOWN = {W{1'b1}};

    state_t       state_q;
    logic [W-1:0] sample_q;
    logic         pending_q;
    logic [W-1:0] refVal_q;
    logic [W-1:0] bin_q;
    logic         binValid_q;
    logic [7:0]   pos_q;
    logic         dir_q;
    logic         stepErr_q;

    logic [W-1:0] binDec;
    logic [W-1:0] delta;
    logic         stepIllegal;

    // Input register: pending_q marks that sample_q holds a sample still to
    // be decoded, so an in-flight sample is dropped by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            pending_q <= g_valid;
            if (g_valid) begin
                sample_q <= g;
            end
        end
    end

    // Gray to binary: each binary bit is the XOR of all Gray bits at and
    // above its position.
    for (genvar i = 0; i < W; i++) begin : g_decode
        assign binDec[i] = ^(sample_q >> i);
    end

    // Modular difference; wrap-around steps fall out of the W-bit subtraction.
    assign delta       = binDec - refVal_q;
    assign stepIllegal = pending_q && (state_q == TRACK) &&
                         (delta != '0) && (delta != STEP_UP) && (delta != STEP_DOWN);

    // Tracking FSM with registered outputs. b keeps following the decoded
    // samples in every state; only the position tracking depends on state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            refVal_q   <= '0;
            bin_q      <= '0;
            binValid_q <= 1'b0;
            pos_q      <= 8'd0;
            dir_q      <= 1'b0;
            stepErr_q  <= 1'b0;
        end else begin
            binValid_q <= pending_q;
            stepErr_q  <= 1'b0;
            if (pending_q) begin
                bin_q <= binDec;
            end
            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        refVal_q <= binDec;
                        state_q  <= TRACK;
                    end
                end
                TRACK: begin
                    if (pending_q) begin
                        refVal_q <= binDec;
                        if (delta == STEP_UP) begin
                            pos_q <= pos_q + 8'd1;
                            dir_q <= 1'b1;
                        end else if (delta == STEP_DOWN) begin
                            pos_q <= pos_q - 8'd1;
                            dir_q <= 1'b0;
                        end else if (stepIllegal) begin
                            stepErr_q <= 1'b1;
                            state_q   <= ERROR;
                        end
                    end
                end
                ERROR: begin
                    // A decode arriving together with err_clr is not used as a
                    // reference; the next sample after IDLE re-seeds instead.
                    if (err_clr) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef GRAY_ERR_CNT_EN
    logic [7:0] errCnt_q;

    // Counts in step with step_err so both become visible on the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errCnt_q <= 8'd0;
        end else if (stepIllegal && (errCnt_q != 8'hFF)) begin
            errCnt_q <= errCnt_q + 8'd1;
        end
    end

    assign err_cnt = errCnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign b        = bin_q;
    assign b_valid  = binValid_q;
    assign pos      = pos_q;
    assign dir      = dir_q;
    assign step_err = stepErr_q;

endmodule

// File: tb/tb_gray2bin_tracker.sv
// -----------------------------------------------------------------------------
// tb_gray2bin_tracker
//
// Directed testbench for gray2bin_tracker with W=4. Inputs change on the
// falling clock edge and outputs are sampled there as well, half a cycle away
// from the rising edge. Expected values are hand-computed Gray/binary codes.
// Build with +define+GRAY_ERR_CNT_EN to exercise the illegal-step counter.
// -----------------------------------------------------------------------------
module tb_gray2bin_tracker;

    localparam int W = 4;

`ifdef GRAY_ERR_CNT_EN
    localparam int ERR_ONE = 1;
    localparam int ERR_TWO = 2;
`else
    localparam int ERR_ONE = 0;
    localparam int ERR_TWO = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] g = '0;
    logic         g_valid = 1'b0;
    logic         err_clr = 1'b0;
    logic [W-1:0] b;
    logic         b_valid;
    logic [7:0]   pos;
    logic         dir;
    logic         step_err;
    logic [7:0]   err_cnt;

    int checks = 0;
    int failures = 0;
    int bvCount = 0;

    gray2bin_tracker #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .g        (g),
        .g_valid  (g_valid),
        .err_clr  (err_clr),
        .b        (b),
        .b_valid  (b_valid),
        .pos      (pos),
        .dir      (dir),
        .step_err (step_err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    // Counts b_valid pulses seen on falling edges.
    always @(negedge clk) begin
        if (b_valid) begin
            bvCount++;
        end
    end

    // Guards against a hung run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [W-1:0] toGray(input logic [W-1:0] v);
        return v ^ (v >> 1);
    endfunction

    // Waits for the next falling edge and drives one cycle of inputs.
    task automatic applyStimulus(input logic [W-1:0] gIn, input logic vIn, input logic clrIn);
        @(negedge clk);
        g       = gIn;
        g_valid = vIn;
        err_clr = clrIn;
    endtask

    // Sends one sample and waits until its result is visible on the outputs.
    task automatic sendSample(input logic [W-1:0] gIn);
        applyStimulus(gIn, 1'b1, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_b", 32'(b), 32'h0);
        checkOutput("rst_bvalid", 32'(b_valid), 32'h0);
        checkOutput("rst_pos", 32'(pos), 32'h0);
        checkOutput("rst_dir", 32'(dir), 32'h0);
        checkOutput("rst_steperr", 32'(step_err), 32'h0);
        checkOutput("rst_errcnt", 32'(err_cnt), 32'h0);
        rst_n = 1'b1;

        // Back-to-back samples 0,1,2,3: first one seeds, then three up steps
        applyStimulus(4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        applyStimulus(4'b0011, 1'b1, 1'b0);
        checkOutput("seq_b0", 32'(b), 32'h0);
        checkOutput("seq_bv0", 32'(b_valid), 32'h1);
        checkOutput("seq_pos0", 32'(pos), 32'h0);
        applyStimulus(4'b0010, 1'b1, 1'b0);
        checkOutput("seq_b1", 32'(b), 32'h1);
        checkOutput("seq_pos1", 32'(pos), 32'h1);
        checkOutput("seq_dir1", 32'(dir), 32'h1);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("seq_b2", 32'(b), 32'h2);
        checkOutput("seq_pos2", 32'(pos), 32'h2);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("seq_b3", 32'(b), 32'h3);
        checkOutput("seq_pos3", 32'(pos), 32'h3);
        checkOutput("seq_bv3", 32'(b_valid), 32'h1);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("seq_bv_end", 32'(b_valid), 32'h0);

        // Walk down to b=0, then wrap down to 15 and back up to 0
        sendSample(4'b0011);
        checkOutput("dn_pos2", 32'(pos), 32'h2);
        checkOutput("dn_dir2", 32'(dir), 32'h0);
        sendSample(4'b0001);
        sendSample(4'b0000);
        checkOutput("dn_pos0", 32'(pos), 32'h0);
        sendSample(4'b1000);
        checkOutput("wrapdn_b", 32'(b), 32'hF);
        checkOutput("wrapdn_pos", 32'(pos), 32'hFF);
        checkOutput("wrapdn_dir", 32'(dir), 32'h0);
        checkOutput("wrapdn_steperr", 32'(step_err), 32'h0);
        sendSample(4'b0000);
        checkOutput("wrapup_pos", 32'(pos), 32'h0);
        checkOutput("wrapup_dir", 32'(dir), 32'h1);

        // Illegal step 1 -> 4
        sendSample(4'b0001);
        checkOutput("pre_err_pos", 32'(pos), 32'h1);
        applyStimulus(4'b0110, 1'b1, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("err_b", 32'(b), 32'h4);
        checkOutput("err_pulse", 32'(step_err), 32'h1);
        checkOutput("err_pos", 32'(pos), 32'h1);
        checkOutput("err_cnt1", 32'(err_cnt), 32'(ERR_ONE));
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("err_pulse_end", 32'(step_err), 32'h0);

        // ERROR: b follows samples, tracking frozen (4 -> 3 would be a down step)
        sendSample(4'b0010);
        checkOutput("errst_b", 32'(b), 32'h3);
        checkOutput("errst_bv", 32'(b_valid), 32'h1);
        checkOutput("errst_pos", 32'(pos), 32'h1);
        checkOutput("errst_dir", 32'(dir), 32'h1);
        checkOutput("errst_steperr", 32'(step_err), 32'h0);

        // Clear error; 6 seeds, 7 steps up
        applyStimulus('0, 1'b0, 1'b1);
        applyStimulus('0, 1'b0, 1'b0);
        sendSample(4'b0101);
        checkOutput("clr_seed_b", 32'(b), 32'h6);
        checkOutput("clr_seed_pos", 32'(pos), 32'h1);
        checkOutput("clr_seed_steperr", 32'(step_err), 32'h0);
        sendSample(4'b0100);
        checkOutput("clr_step_pos", 32'(pos), 32'h2);
        checkOutput("clr_step_dir", 32'(dir), 32'h1);

        // err_clr in TRACK is ignored: 7 -> 6 still tracked as down
        applyStimulus('0, 1'b0, 1'b1);
        sendSample(4'b0101);
        checkOutput("trk_clr_pos", 32'(pos), 32'h1);
        checkOutput("trk_clr_dir", 32'(dir), 32'h0);

        // 6 -> 0 illegal, then err_clr coincides with decode of 2
        sendSample(4'b0000);
        checkOutput("err2_pulse", 32'(step_err), 32'h1);
        checkOutput("err_cnt2", 32'(err_cnt), 32'(ERR_TWO));
        applyStimulus(4'b0011, 1'b1, 1'b0);
        applyStimulus('0, 1'b0, 1'b1);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("coinc_b", 32'(b), 32'h2);
        checkOutput("coinc_pos", 32'(pos), 32'h1);
        sendSample(4'b0010);
        checkOutput("coinc_seed_pos", 32'(pos), 32'h1);
        sendSample(4'b0110);
        checkOutput("coinc_step_pos", 32'(pos), 32'h2);

        // 125 up steps with 0..3 idle gaps to reach 127
        applyStimulus('0, 1'b0, 1'b0);
        bvCount = 0;
        for (int i = 1; i <= 125; i++) begin
            applyStimulus(toGray(W'(4 + i)), 1'b1, 1'b0);
            repeat (i % 4) applyStimulus('0, 1'b0, 1'b0);
        end
        repeat (3) applyStimulus('0, 1'b0, 1'b0);
        checkOutput("gap_bvcount", 32'(bvCount), 32'd125);
        checkOutput("pre_wrap_pos", 32'(pos), 32'h7F);
        sendSample(4'b0011);
        checkOutput("pos_wrap_up", 32'(pos), 32'h80);
        sendSample(4'b0001);
        checkOutput("pos_wrap_dn", 32'(pos), 32'h7F);
        checkOutput("pos_wrap_dn_dir", 32'(dir), 32'h0);

        // Reset one cycle after a sample is captured
        applyStimulus(4'b0111, 1'b1, 1'b0);
        @(negedge clk);
        rst_n   = 1'b0;
        g_valid = 1'b0;
        #1;
        checkOutput("rst2_pos", 32'(pos), 32'h0);
        checkOutput("rst2_b", 32'(b), 32'h0);
        checkOutput("rst2_dir", 32'(dir), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bvCount = 0;
        repeat (3) applyStimulus('0, 1'b0, 1'b0);
        checkOutput("rst2_no_bv", 32'(bvCount), 32'd0);
        checkOutput("rst2_errcnt", 32'(err_cnt), 32'h0);
        sendSample(4'b0011);
        checkOutput("rst2_seed_b", 32'(b), 32'h2);
        checkOutput("rst2_seed_pos", 32'(pos), 32'h0);
        sendSample(4'b0010);
        checkOutput("rst2_step_pos", 32'(pos), 32'h1);
        checkOutput("rst2_step_dir", 32'(dir), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
